i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares the single EFB I2C master command interface between two requesters: requester 0 is the BNO055 IMU driver and requester 1 is a second sensor driver, such as the lidar or altimeter.
- Sits between the sensor drivers and the I2C master wrapper.
- Arbitrates round-robin and runs exactly one byte transaction per grant.
- Applies a watchdog timeout so a hung slave cannot stall the other requester.

Parameters:
- TIMEOUT_CYCLES, 760000: sys_clk cycles allowed from go until master_done; 20 ms at 38 MHz.
- TO_WIDTH, 20: timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  system clock; 38 MHz OSCH.
- resetn  in  1  asynchronous active-low reset.
- req_0, req_1  in  1  level request from each driver.
- rw_0, rw_1  in  1  1=read, 0=write.
- addr_0, addr_1  in  7  slave address.
- reg_0, reg_1  in  8  target register.
- wdata_0, wdata_1  in  8  write byte.
- grant_0, grant_1  out  1  requester owns the bus.
- done_0, done_1  out  1  1-cycle transaction-complete pulse.
- err_0, err_1  out  1  1-cycle pulse, coincident with done_x, on timeout.
- rdata  out  8  last read byte; valid while done_x is high.
- go  out  1  1-cycle start pulse to the master.
- rw_out  out  1  registered command field to the master.
- addr_out  out  7  registered command field to the master.
- reg_out  out  8  registered command field to the master.
- wdata_out  out  8  registered command field to the master.
- master_busy  in  1  master transaction in progress.
- master_done  in  1  1-cycle master completion pulse.
- master_rdata  in  8  byte returned by the master.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant=1, so requester 0 wins the first tie.
  - Timeout counter 0.
- Reset is asynchronous and takes effect immediately, including mid-transaction. go and grants drop at once. No done or err pulse is issued for the aborted transaction.
- IDLE:
  - Sample req_0/req_1.
  - One request: select it.
  - Both requests: select the requester that is not last_grant.
  - Next cycle enter ISSUE.
- ISSUE (1 cycle):
  - grant_x=1 and go=1.
  - rw_out/addr_out/reg_out/wdata_out are registered from requester x's inputs as sampled in the IDLE cycle.
  - last_grant<=x; timeout counter cleared.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - grant_x held.
  - Go to WAIT_DONE on master_busy=1.
  - If master_done=1 arrives while still in WAIT_BUSY, complete directly (fast master).
- WAIT_DONE:
  - On master_done=1: rdata<=master_rdata (also for writes), done_x=1 for 1 cycle, go to RELEASE.
- Timeout:
  - The counter increments every cycle in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without master_done: done_x=1, err_x=1, rdata unchanged, go to RELEASE.
  - If master_done and timeout coincide, master_done wins and err_x=0.
- RELEASE (1 cycle):
  - All grants 0; return to IDLE.
  - This guarantees at least 1 idle cycle between transactions.
- Minimum request-to-go latency: 1 cycle. A request seen in IDLE at cycle N gives go at N+1.
- Command output fields hold their values until the next ISSUE.
- grant_0 and grant_1 are never both 1; assert this in the bench.
- go is asserted only in ISSUE, at most once per grant.
- done_x/err_x are asserted only for the currently granted x.
- Requester deasserts req mid-transaction: the transaction still completes (I2C cannot abort), and done_x still pulses.
- Requester holding req high after done_x gets a new grant only after RELEASE+IDLE. If the other requester is pending, the other wins (round-robin), so there is no starvation.
- Requester inputs changing after the IDLE sample cycle have no effect on the current transaction.
- master_done outside WAIT_BUSY/WAIT_DONE is ignored.
- master_busy stuck high after done is ignored; the next transaction still issues go.

Test Plan:
1. Single read. req_0=1, rw_0=1, addr_0=7'h28, reg_0=8'h1A; master returns busy 2 cycles later and done with master_rdata=8'hA5 after 100 cycles. Expect: go 1 cycle after req; addr_out=7'h28, reg_out=8'h1A; done_0 pulse with rdata=8'hA5, err_0=0; grant_0 low 1 cycle after done_0.
2. Simultaneous requests. req_0=req_1=1 held for 4 transactions. Expect grant order 0,1,0,1; one go per grant; grants never overlap; at least 1 idle cycle between grants.
3. Timeout. Set TIMEOUT_CYCLES=50; req_1=1; master_busy=1, master_done never asserted. Expect done_1=err_1=1 exactly 50 cycles after go; rdata unchanged; req_0 then granted next.
4. Timeout race. master_done arrives on the same cycle the counter hits TIMEOUT_CYCLES-1. Expect done_x=1, err_x=0, rdata=master_rdata.
5. Reset mid-transaction. Assert resetn=0 during WAIT_DONE. Expect all outputs 0 immediately and no done pulse. After release, req_0 and req_1 both high gives requester 0 first.
6. Request drop and field change. req_0 drops and addr_0 changes the cycle after go. Expect addr_out unchanged; done_0 still pulses on master_done.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C master command interface between two sensor drivers.
// Requester 0 is the IMU driver and requester 1 is a second sensor driver. The arbiter
// grants round-robin and runs one byte transaction per grant. A watchdog ends a
// transaction whose slave never completes, so the other requester is not stalled.
//
// Ports:
//   sys_clk, resetn             clock, asynchronous active-low reset
//   req_x, rw_x, addr_x, reg_x, wdata_x
//                               request and command fields from requester x
//   grant_x, done_x, err_x      ownership, completion pulse, timeout pulse to requester x
//   rdata                       last read byte, valid while done_x is high
//   go, rw_out, addr_out, reg_out, wdata_out
//                               start pulse and registered command to the master
//   master_busy, master_done, master_rdata
//                               status and read byte from the master
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 760000,
  parameter int unsigned TO_WIDTH       = 20
) (
  input  logic       sys_clk,
  input  logic       resetn,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       rw_0,
  input  logic       rw_1,
  input  logic [6:0] addr_0,
  input  logic [6:0] addr_1,
  input  logic [7:0] reg_0,
  input  logic [7:0] reg_1,
  input  logic [7:0] wdata_0,
  input  logic [7:0] wdata_1,
  output logic       grant_0,
  output logic       grant_1,
  output logic       done_0,
  output logic       done_1,
  output logic       err_0,
  output logic       err_1,
  output logic [7:0] rdata,
  output logic       go,
  output logic       rw_out,
  output logic [6:0] addr_out,
  output logic [7:0] reg_out,
  output logic [7:0] wdata_out,
  input  logic       master_busy,
  input  logic       master_done,
  input  logic [7:0] master_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StRelease
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;        // requester owning the current transaction
  logic                last_q, last_d;      // requester granted most recently
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [6:0]          addr_q, addr_d;
  logic [7:0]          reg_q, reg_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;

  logic in_wait;
  logic timeout;
  logic pick;

  assign in_wait = (state_q == StWaitBusy) || (state_q == StWaitDone);
  assign timeout = (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  // On a tie the requester that was not granted last wins.
  assign pick    = (req_0 && req_1) ? ~last_q : req_1;

  // State register
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_0 || req_1) begin
          sel_d   = pick;
          // Command is captured here so later changes on the requester side are ignored.
          rw_d    = pick ? rw_1    : rw_0;
          addr_d  = pick ? addr_1  : addr_0;
          reg_d   = pick ? reg_1   : reg_0;
          wdata_d = pick ? wdata_1 : wdata_0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        last_d  = sel_q;
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy, StWaitDone: begin
        cnt_d = cnt_q + TO_WIDTH'(1);
        // master_done takes priority over a coincident timeout.
        if (master_done) begin
          rdata_d = master_rdata;
          state_d = StRelease;
        end else if (timeout) begin
          state_d = StRelease;
        end else if ((state_q == StWaitBusy) && master_busy) begin
          state_d = StWaitDone;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. done/err are Mealy on master_done so the pulse lands while the grant is held.
  always_comb begin
    logic active;
    logic fin;
    logic fail;
    active    = (state_q == StIssue) || in_wait;
    fin       = in_wait && (master_done || timeout);
    fail      = in_wait && !master_done && timeout;
    grant_0   = active && !sel_q;
    grant_1   = active && sel_q;
    go        = (state_q == StIssue);
    done_0    = fin && !sel_q;
    done_1    = fin && sel_q;
    err_0     = fail && !sel_q;
    err_1     = fail && sel_q;
    // Bypass so the new byte is already visible during the done pulse.
    rdata     = (in_wait && master_done) ? master_rdata : rdata_q;
    rw_out    = rw_q;
    addr_out  = addr_q;
    reg_out   = reg_q;
    wdata_out = wdata_q;
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a short watchdog (TIMEOUT_CYCLES = 50).
module tb_i2c_bus_arbiter;

  logic       sys_clk = 1'b0;
  logic       resetn;
  logic       req_0, req_1, rw_0, rw_1;
  logic [6:0] addr_0, addr_1;
  logic [7:0] reg_0, reg_1, wdata_0, wdata_1;
  logic       grant_0, grant_1, done_0, done_1, err_0, err_1;
  logic [7:0] rdata;
  logic       go, rw_out;
  logic [6:0] addr_out;
  logic [7:0] reg_out, wdata_out;
  logic       master_busy, master_done;
  logic [7:0] master_rdata;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  i2c_bus_arbiter #(
    .TIMEOUT_CYCLES(50),
    .TO_WIDTH      (20)
  ) dut (
    .sys_clk     (sys_clk),
    .resetn      (resetn),
    .req_0       (req_0),
    .req_1       (req_1),
    .rw_0        (rw_0),
    .rw_1        (rw_1),
    .addr_0      (addr_0),
    .addr_1      (addr_1),
    .reg_0       (reg_0),
    .reg_1       (reg_1),
    .wdata_0     (wdata_0),
    .wdata_1     (wdata_1),
    .grant_0     (grant_0),
    .grant_1     (grant_1),
    .done_0      (done_0),
    .done_1      (done_1),
    .err_0       (err_0),
    .err_1       (err_1),
    .rdata       (rdata),
    .go          (go),
    .rw_out      (rw_out),
    .addr_out    (addr_out),
    .reg_out     (reg_out),
    .wdata_out   (wdata_out),
    .master_busy (master_busy),
    .master_done (master_done),
    .master_rdata(master_rdata)
  );

  // Grants must never overlap.
  always @(negedge sys_clk) begin
    assert (!(grant_0 && grant_1)) else begin
      errors++;
      $error("FAIL grant_overlap: observed both grants 1 expected at most one");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    req_0 = 0; req_1 = 0; rw_0 = 0; rw_1 = 0;
    addr_0 = '0; addr_1 = '0; reg_0 = '0; reg_1 = '0; wdata_0 = '0; wdata_1 = '0;
    master_busy = 0; master_done = 0; master_rdata = '0;

    // Reset state
    #2;
    chk("rst_go", go, 0);
    chk("rst_grant0", grant_0, 0);
    chk("rst_grant1", grant_1, 0);
    chk("rst_done0", done_0, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_addr_out", addr_out, 7'h00);
    cyc(2);
    resetn = 1'b1;

    // Simultaneous requests: order 0,1,0,1 from reset, idle cycle between grants
    req_0 = 1; req_1 = 1; rw_0 = 1; rw_1 = 0;
    addr_0 = 7'h11; addr_1 = 7'h22; reg_0 = 8'h01; reg_1 = 8'h02;
    for (int i = 0; i < 4; i++) begin
      cyc(1); #1;
      chk("rr_go", go, 1);
      chk("rr_grant0", grant_0, (i % 2 == 0));
      chk("rr_grant1", grant_1, (i % 2 == 1));
      chk("rr_addr_out", addr_out, (i % 2 == 0) ? 7'h11 : 7'h22);
      cyc(1);
      master_done = 1; master_rdata = 8'h40 + 8'(i);
      #1;
      chk("rr_go_once", go, 0);
      chk("rr_done0", done_0, (i % 2 == 0));
      chk("rr_done1", done_1, (i % 2 == 1));
      chk("rr_err", {err_0, err_1}, 0);
      chk("rr_rdata", rdata, 8'h40 + 8'(i));
      cyc(1);
      master_done = 0;
      #1;
      chk("rr_release_grants", {grant_0, grant_1}, 0);
      chk("rr_release_done", {done_0, done_1}, 0);
      cyc(1);
      if (i == 3) begin
        req_0 = 0; req_1 = 0;
      end
      #1;
      chk("rr_idle_grants", {grant_0, grant_1}, 0);
      chk("rr_idle_go", go, 0);
    end

    // Single read with request drop and field change after go
    req_0 = 1; rw_0 = 1; addr_0 = 7'h28; reg_0 = 8'h1A; wdata_0 = 8'h00;
    #1;
    chk("rd_idle_go", go, 0);
    cyc(1);
    chk("rd_go", go, 1);
    chk("rd_grant0", grant_0, 1);
    chk("rd_rw_out", rw_out, 1);
    chk("rd_addr_out", addr_out, 7'h28);
    chk("rd_reg_out", reg_out, 8'h1A);
    req_0 = 0; addr_0 = 7'h55;
    cyc(1);
    chk("rd_go_drop", go, 0);
    chk("rd_addr_hold", addr_out, 7'h28);
    chk("rd_grant_held", grant_0, 1);
    cyc(1);
    master_busy = 1;
    cyc(26);
    master_done = 1; master_rdata = 8'hA5;
    #1;
    chk("rd_done0", done_0, 1);
    chk("rd_done1", done_1, 0);
    chk("rd_err0", err_0, 0);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_grant_at_done", grant_0, 1);
    chk("rd_addr_still", addr_out, 7'h28);
    cyc(1);
    master_done = 0; master_busy = 0; master_rdata = 8'hEE;
    #1;
    chk("rd_grant_after", grant_0, 0);
    chk("rd_done_after", done_0, 0);
    chk("rd_rdata_hold", rdata, 8'hA5);
    cyc(1);

    // Timeout on requester 1, then requester 0 granted
    req_1 = 1; rw_1 = 0; addr_1 = 7'h30; reg_1 = 8'h05; wdata_1 = 8'hC3;
    cyc(1);
    chk("to_go", go, 1);
    chk("to_grant1", grant_1, 1);
    chk("to_wdata_out", wdata_out, 8'hC3);
    chk("to_rw_out", rw_out, 0);
    req_1 = 0; req_0 = 1; master_busy = 1;
    cyc(49);
    chk("to_early_done", done_1, 0);
    chk("to_early_grant", grant_1, 1);
    cyc(1);
    chk("to_done1", done_1, 1);
    chk("to_err1", err_1, 1);
    chk("to_err0", err_0, 0);
    chk("to_rdata", rdata, 8'hA5);
    cyc(1);
    chk("to_release", {grant_0, grant_1, err_1}, 0);
    cyc(2);
    // master_busy still stuck high
    chk("to_next_go", go, 1);
    chk("to_next_grant0", grant_0, 1);

    // Timeout race: master_done on the last counter cycle wins
    req_0 = 0;
    cyc(50);
    master_done = 1; master_rdata = 8'h3C;
    #1;
    chk("race_done0", done_0, 1);
    chk("race_err0", err_0, 0);
    chk("race_rdata", rdata, 8'h3C);
    cyc(1);
    master_done = 0; master_busy = 0;
    #1;
    chk("race_release", {grant_0, grant_1}, 0);
    chk("race_rdata_hold", rdata, 8'h3C);
    cyc(1);
    // Stray master_done in IDLE is ignored
    master_done = 1; master_rdata = 8'h99;
    #1;
    chk("stray_done", {done_0, done_1}, 0);
    chk("stray_rdata", rdata, 8'h3C);
    cyc(1);
    master_done = 0;

    // Reset in WAIT_DONE
    req_0 = 1;
    cyc(1);
    req_0 = 0; master_busy = 1;
    cyc(2);
    chk("mid_grant_before", grant_0, 1);
    resetn = 0;
    #1;
    chk("mid_grant0", grant_0, 0);
    chk("mid_go", go, 0);
    chk("mid_rdata", rdata, 8'h00);
    chk("mid_addr_out", addr_out, 7'h00);
    cyc(1);
    master_done = 1;
    #1;
    chk("mid_no_done", {done_0, done_1, err_0, err_1}, 0);
    master_done = 0; master_busy = 0;
    resetn = 1;
    req_0 = 1; req_1 = 1;
    cyc(1);
    chk("post_rst_grant0", grant_0, 1);
    chk("post_rst_grant1", grant_1, 0);
    chk("post_rst_go", go, 1);
    req_0 = 0; req_1 = 0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
